serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter AW, default 7, address field width in bits (1..32).
REQ-002 Parameter DW, default 8, data field width in bits (1..32).
REQ-003 Parameter DEPTH, default 4, frame FIFO depth; power of 2, at least 2.
REQ-004 Parameter MSB_FIRST, default 1; 1 = fields shifted MSB first, 0 = LSB first.
REQ-005 clk_in  input  1  system clock; all logic on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of FIFO and transmitter.
REQ-008 in_valid  input  1  frame request.
REQ-009 in_ready  output  1  FIFO can accept a frame.
REQ-010 in_addr  input  AW  address field.
REQ-011 in_data  input  DW  data field.
REQ-012 out_d  output  1  serial data, tri-state; 'Z' when not driving.
REQ-013 out_c  output  1  serial strobe; the receiver samples out_d on its rising edge.
REQ-014 busy  output  1  frame in progress.
REQ-015 fifo_level  output  $clog2(DEPTH+1)  number of queued frames, excluding the frame in transmission.

Function
REQ-016 Accept = in_valid && in_ready at a rising edge; {in_addr, in_data} is written to the FIFO.
REQ-017 in_ready = (fifo_level < DEPTH), registered-state based; no bypass path.
REQ-018 While in_ready=0, in_valid is ignored and no frame is lost or overwritten.
REQ-019 Bit period = 2 clk_in cycles: out_c=0 in cycle 1 and out_c=1 in cycle 2; out_d is stable across both cycles.
REQ-020 Transmitter states and order: IDLE, START, ADDR, GAP_A, DATA, STOP, GAP_D.
REQ-021 START: 1 bit period, out_d=0.
REQ-022 ADDR: AW bit periods, address bits in MSB_FIRST order.
REQ-023 GAP_A: 1 bit period, out_d='Z'.
REQ-024 DATA: DW bit periods, data bits in MSB_FIRST order.
REQ-025 STOP: 1 bit period, out_d=0.
REQ-026 GAP_D: 1 bit period, out_d='Z'.
REQ-027 Frame length = AW+DW+4 bit periods, i.e. 38 clk_in cycles at the default parameters.
REQ-028 IDLE: out_d='Z', out_c=0, busy=0.
REQ-029 busy=1 in all states other than IDLE.
REQ-030 IDLE with a non-empty FIFO: pop at the next edge; START begins on that edge.
REQ-031 Pushing into an empty FIFO while IDLE: START begins 1 cycle after the accepting edge.
REQ-032 GAP_D end with a non-empty FIFO: pop and go directly to START, with no extra idle cycle.
REQ-033 GAP_D end with an empty FIFO: go to IDLE.
REQ-034 Push and pop on the same edge: fifo_level unchanged and data order preserved.
REQ-035 Read and write pointers wrap modulo DEPTH.
REQ-036 Bit counter width is $clog2(max(AW,DW)+1); the counter never indexes beyond its field.
REQ-037 flush=1: next edge sets IDLE, fifo_level=0, out_d='Z', out_c=0; any frame in progress is truncated.
REQ-038 flush and an accept on the same edge: flush wins and the pushed frame is dropped.
REQ-039 out_d and out_c are driven from registers only; no gated or combinational clock output.

Reset
REQ-040 While reset_n=0, asynchronously: state=IDLE, out_d='Z', out_c=0, busy=0, fifo_level=0, in_ready=1, pointers=0.
REQ-041 Reset during a frame aborts it immediately and discards all queued frames; there is no partial output after release.
REQ-042 The first accept is possible on the first rising edge after reset_n deasserts.

Verification (defaults unless noted)
REQ-043 Reset: reset_n=0 at any time -> out_d='Z', out_c=0, in_ready=1, fifo_level=0 within the same cycle.
REQ-044 Single frame: A=7'b1111111, D=8'b11111111 -> values at out_c rising edges = 0, 1111111, Z, 11111111, 0, Z; busy high for 38 cycles.
REQ-045 LSB-first: MSB_FIRST=0, A=7'b1000011, D=8'b10011111 -> sampled sequence = 0, 1100001, Z, 11111001, 0, Z.
REQ-046 Back-to-back: 6 pushes on consecutive cycles from idle -> 5 accepted (1 in flight + 4 queued), in_ready=0 on the 6th push; 5 contiguous frames with no idle bit periods between them, sent in push order.
REQ-047 Abort: reset_n=0 in the middle of DATA -> out_d='Z' and out_c=0 at once; no further frames after release.
REQ-048 Flush: flush=1 with a simultaneous push, 2 frames queued and a frame in progress -> next edge fifo_level=0, busy=0, out_d='Z'; the pushed frame never appears on out_d.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: queues {address, data} frames in a small FIFO and shifts
// each one out as START, ADDR, GAP_A, DATA, STOP, GAP_D. Every bit lasts two
// clk_in cycles, with out_c low in the first cycle and high in the second.
// out_d floats during the gaps and while idle.
module serial_frame_tx #(
  parameter int AW        = 7,
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk_in,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AW-1:0]                in_addr,
  input  logic [DW-1:0]                in_data,
  output logic                         out_d,
  output logic                         out_c,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int MAXW = (AW > DW) ? AW : DW;
  localparam int CW   = $clog2(MAXW+1);
  localparam int FW   = AW + DW;

  typedef enum logic [2:0] {IDLE, START, ADDR, GAP_A, DATA, STOP, GAP_D} state_t;

  state_t          state, stN;
  logic            phase, phN;
  logic [CW-1:0]   bitCnt, cntN;
  logic            pop, push;
  logic [FW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [AW-1:0]   curAddr;
  logic [DW-1:0]   curData;
  logic            oeReg, dReg;
  logic            oeN, dN;
  logic [CW-1:0]   aIdx, dIdx;
  logic            aBit, dBit;

  assign in_ready = (fifo_level < LW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign busy     = (state != IDLE);
  assign out_d    = oeReg ? dReg : 1'bz;

  // Next transmitter state: a bit advances only at the end of its high phase
  always_comb begin
    stN  = state;
    phN  = phase;
    cntN = bitCnt;
    pop  = 1'b0;
    if (state == IDLE) begin
      if (fifo_level != '0) begin
        stN  = START;
        phN  = 1'b0;
        pop  = 1'b1;
      end
    end else if (!phase) begin
      phN = 1'b1;
    end else begin
      phN = 1'b0;
      case (state)
        START: begin
          stN  = ADDR;
          cntN = '0;
        end
        ADDR: begin
          if (bitCnt == CW'(AW-1)) begin
            stN  = GAP_A;
            cntN = '0;
          end else begin
            cntN = bitCnt + CW'(1);
          end
        end
        GAP_A: begin
          stN  = DATA;
          cntN = '0;
        end
        DATA: begin
          if (bitCnt == CW'(DW-1)) begin
            stN  = STOP;
            cntN = '0;
          end else begin
            cntN = bitCnt + CW'(1);
          end
        end
        STOP: stN = GAP_D;
        GAP_D: begin
          if (fifo_level != '0) begin
            stN = START;
            pop = 1'b1;
          end else begin
            stN = IDLE;
          end
        end
        default: stN = IDLE;
      endcase
    end
    if (flush) begin
      stN  = IDLE;
      phN  = 1'b0;
      cntN = '0;
      pop  = 1'b0;
    end
  end

  // Line value for the upcoming cycle, so out_d/out_c can be registered
  always_comb begin
    aIdx = (MSB_FIRST != 0) ? (CW'(AW-1) - cntN) : cntN;
    dIdx = (MSB_FIRST != 0) ? (CW'(DW-1) - cntN) : cntN;
    aBit = |(curAddr & (AW'(1) << aIdx));
    dBit = |(curData & (DW'(1) << dIdx));
    oeN  = 1'b0;
    dN   = 1'b0;
    case (stN)
      START, STOP: oeN = 1'b1;
      ADDR: begin
        oeN = 1'b1;
        dN  = aBit;
      end
      DATA: begin
        oeN = 1'b1;
        dN  = dBit;
      end
      default: ;
    endcase
  end

  // Transmitter FSM with registered line outputs and the latched current frame
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      phase   <= 1'b0;
      bitCnt  <= '0;
      out_c   <= 1'b0;
      oeReg   <= 1'b0;
      dReg    <= 1'b0;
      curAddr <= '0;
      curData <= '0;
    end else begin
      state  <= stN;
      phase  <= phN;
      bitCnt <= cntN;
      out_c  <= (stN != IDLE) && phN;
      oeReg  <= oeN;
      dReg   <= dN;
      if (pop) {curAddr, curData} <= mem[rdPtr];
    end
  end

  // FIFO pointers and occupancy; flush and reset empty the queue
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Frame storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_in) begin
    if (push) mem[wrPtr] <= {in_addr, in_data};
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. The reference model treats the transmitter
// as a single server taking a fixed number of cycles per frame, and predicts
// the serial symbol stream seen at out_c rising edges from the accepted frames.
module tb_serial_frame_tx;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int FR    = (AW + DW + 4) * 2;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_c, busy;
  logic [LW-1:0] fifo_level;
  wire           out_d;

  logic          in_validL = 1'b0;
  logic [AW-1:0] in_addrL = '0;
  logic [DW-1:0] in_dataL = '0;
  logic          in_readyL, out_cL, busyL;
  logic [LW-1:0] fifo_levelL;
  wire           out_dL;

  always #5 clk_in = ~clk_in;

  serial_frame_tx #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .out_d(out_d),
    .out_c(out_c), .busy(busy), .fifo_level(fifo_level));

  serial_frame_tx #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MSB_FIRST(0)) dutL (
    .clk_in(clk_in), .reset_n(reset_n), .flush(flush), .in_valid(in_validL),
    .in_ready(in_readyL), .in_addr(in_addrL), .in_data(in_dataL), .out_d(out_dL),
    .out_c(out_cL), .busy(busyL), .fifo_level(fifo_levelL));

  // Symbol codes: 0, 1, 2 = high impedance
  logic [1:0] dSym, dSymL;
  assign dSym  = (out_d  === 1'bz) ? 2'd2 : ((out_d  === 1'b1) ? 2'd1 : 2'd0);
  assign dSymL = (out_dL === 1'bz) ? 2'd2 : ((out_dL === 1'b1) ? 2'd1 : 2'd0);

  logic       prevC = 1'b0, prevCL = 1'b0;
  logic [1:0] rxSym[$], rxSymL[$];

  // Receiver: capture out_d at each out_c rising edge
  always @(negedge clk_in) begin
    if (out_c && !prevC) rxSym.push_back(dSym);
    if (out_cL && !prevCL) rxSymL.push_back(dSymL);
    prevC  <= out_c;
    prevCL <= out_cL;
  end

  int         checks = 0, errors = 0;
  int         edgeN = 0;
  int         sched[$];
  int         lastEnd = 0;
  logic [1:0] expSym[$], expSymL[$];
  int         rxBase = 0;
  int         bFirst = -1, bLast = -1, bCount = 0;

  function automatic int queuedAt(input int n);
    int c = 0;
    foreach (sched[i]) if (sched[i] > n) c++;
    return c;
  endfunction

  function automatic bit activeAt(input int n);
    foreach (sched[i]) if (sched[i] <= n && n < sched[i] + FR) return 1'b1;
    return 1'b0;
  endfunction

  task automatic addExp(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit msb, input bit toL);
    logic [1:0] q[$];
    q.push_back(2'd0);
    for (int i = 0; i < AW; i++) q.push_back({1'b0, a[msb ? AW-1-i : i]});
    q.push_back(2'd2);
    for (int i = 0; i < DW; i++) q.push_back({1'b0, d[msb ? DW-1-i : i]});
    q.push_back(2'd0);
    q.push_back(2'd2);
    foreach (q[i]) begin
      if (toL) expSymL.push_back(q[i]);
      else     expSym.push_back(q[i]);
    end
  endtask

  task automatic clearStreams();
    expSym.delete();
    rxBase = rxSym.size();
  endtask

  task automatic modelClear();
    sched.delete();
    lastEnd = 0;
  endtask

  // One clock edge on the main instance, with model update and status checks
  task automatic step();
    bit acc;
    int s;
    acc = in_valid && !flush && (queuedAt(edgeN) < DEPTH);
    @(posedge clk_in);
    edgeN++;
    if (flush) begin
      modelClear();
    end else if (acc) begin
      s = (edgeN + 1 > lastEnd) ? edgeN + 1 : lastEnd;
      sched.push_back(s);
      lastEnd = s + FR;
      addExp(in_addr, in_data, 1'b1, 1'b0);
    end
    while (sched.size() > 0 && sched[0] + FR <= edgeN) void'(sched.pop_front());
    #1;
    if (busy) begin
      if (bFirst < 0) bFirst = edgeN;
      bLast = edgeN;
      bCount++;
    end
    checks++;
    if (fifo_level !== LW'(queuedAt(edgeN))) begin
      errors++;
      $display("FAIL fifo_level @%0d: got %0d expected %0d", edgeN, fifo_level, queuedAt(edgeN));
    end
    checks++;
    if (in_ready !== (queuedAt(edgeN) < DEPTH)) begin
      errors++;
      $display("FAIL in_ready @%0d: got %0b expected %0b", edgeN, in_ready, queuedAt(edgeN) < DEPTH);
    end
    checks++;
    if (busy !== activeAt(edgeN)) begin
      errors++;
      $display("FAIL busy @%0d: got %0b expected %0b", edgeN, busy, activeAt(edgeN));
    end
  endtask

  task automatic waitIdle(input int maxSteps);
    int n = 0;
    in_valid = 1'b0;
    while ((sched.size() != 0 || busy) && n < maxSteps) begin
      step();
      n++;
    end
    checks++;
    if (busy || sched.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected busy=0 pending=0", busy, sched.size());
    end
  endtask

  task automatic checkStream(input string nm);
    int n = rxSym.size() - rxBase;
    checks++;
    if (n != expSym.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d symbols expected %0d", nm, n, expSym.size());
    end
    for (int i = 0; i < expSym.size() && i < n; i++) begin
      checks++;
      if (rxSym[rxBase+i] !== expSym[i]) begin
        errors++;
        $display("FAIL %s_sym[%0d]: got %0d expected %0d", nm, i, rxSym[rxBase+i], expSym[i]);
      end
    end
    clearStreams();
  endtask

  task automatic checkIdleOutputs(input string nm);
    checks++;
    if (dSym !== 2'd2 || out_c !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || fifo_level !== '0) begin
      errors++;
      $display("FAIL %s: got d=%0d c=%0b busy=%0b rdy=%0b lvl=%0d expected d=2 c=0 busy=0 rdy=1 lvl=0",
               nm, dSym, out_c, busy, in_ready, fifo_level);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2 checkIdleOutputs("reset_state");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) reset_n = 1'b1;
    modelClear();
    clearStreams();
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_addr  = 7'b1111111;
    in_data  = 8'b11111111;
    bFirst = -1; bLast = -1; bCount = 0;
    step();
    in_valid = 1'b0;
    waitIdle(200);
    checks++;
    if (bCount != FR || bLast - bFirst + 1 != FR) begin
      errors++;
      $display("FAIL single_busy: got %0d cycles (span %0d) expected %0d", bCount, bLast - bFirst + 1, FR);
    end
    checkStream("single");
  endtask

  task automatic test_lsb();
    int baseL = rxSymL.size();
    int bc = 0;
    expSymL.delete();
    in_validL = 1'b1;
    in_addrL  = 7'b1000011;
    in_dataL  = 8'b10011111;
    addExp(in_addrL, in_dataL, 1'b0, 1'b1);
    @(posedge clk_in);
    #1 in_validL = 1'b0;
    repeat (FR + 10) begin
      @(posedge clk_in);
      #1 if (busyL) bc++;
    end
    checks++;
    if (bc != FR) begin
      errors++;
      $display("FAIL lsb_busy: got %0d expected %0d", bc, FR);
    end
    checks++;
    if (rxSymL.size() - baseL != expSymL.size()) begin
      errors++;
      $display("FAIL lsb_len: got %0d expected %0d", rxSymL.size() - baseL, expSymL.size());
    end
    for (int i = 0; i < expSymL.size() && baseL + i < rxSymL.size(); i++) begin
      checks++;
      if (rxSymL[baseL+i] !== expSymL[i]) begin
        errors++;
        $display("FAIL lsb_sym[%0d]: got %0d expected %0d", i, rxSymL[baseL+i], expSymL[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic rdy6 = 1'b1;
    bFirst = -1; bLast = -1; bCount = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'($urandom);
      in_data  = DW'($urandom);
      if (in_ready) acc++;
      if (k == 5) rdy6 = in_ready;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 5 || rdy6 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got %0d accepted, ready@6th=%0b expected 5 accepted, ready@6th=0", acc, rdy6);
    end
    waitIdle(400);
    checks++;
    if (bCount != 5 * FR || bLast - bFirst + 1 != 5 * FR) begin
      errors++;
      $display("FAIL b2b_contig: got %0d busy cycles span %0d expected %0d", bCount, bLast - bFirst + 1, 5 * FR);
    end
    checkStream("b2b");
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_addr  = AW'($urandom);
      in_data  = DW'($urandom);
      step();
    end
    waitIdle(600);
    checkStream("random");
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'($urandom);
      in_data  = DW'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 7'h55;
    in_data  = 8'hA5;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkIdleOutputs("flush_state");
    clearStreams();
    repeat (100) step();
    checks++;
    if (rxSym.size() != rxBase) begin
      errors++;
      $display("FAIL flush_residue: got %0d symbols expected 0", rxSym.size() - rxBase);
    end
    clearStreams();
  endtask

  task automatic test_abort();
    int s;
    in_valid = 1'b1;
    in_addr  = AW'($urandom);
    in_data  = DW'($urandom);
    step();
    in_addr  = AW'($urandom);
    step();
    in_valid = 1'b0;
    s = sched[0];
    while (edgeN < s + 22) step();
    checks++;
    if (dSym === 2'd2) begin
      errors++;
      $display("FAIL abort_pre_drive: got d=%0d expected driven 0/1", dSym);
    end
    #3 reset_n = 1'b0;
    #1 checkIdleOutputs("abort_state");
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) reset_n = 1'b1;
    modelClear();
    clearStreams();
    repeat (100) step();
    checks++;
    if (rxSym.size() != rxBase) begin
      errors++;
      $display("FAIL abort_residue: got %0d symbols expected 0", rxSym.size() - rxBase);
    end
    clearStreams();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb();
    test_back_to_back();
    test_random();
    test_flush();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
